// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types and constants
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int UART_DIV_W = 24;
    localparam int UART_MIN_DIV = 4;
    localparam int UART_DEFAULT_DIV = 434;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop pad synchronizer with falling-edge detect
module uart_rx_sync (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic rx_i,
    output logic rx_s,
    output logic fall
);
    logic meta;
    logic prev_s;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) {meta, rx_s, prev_s} <= 3'b111;
        else {meta, rx_s, prev_s} <= {rx_i, meta, rx_s};
    end
    assign fall = prev_s & ~rx_s;
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with one-entry holding register and sticky error flags
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DIV_W   = UART_DIV_W,
    parameter int MIN_DIV = UART_MIN_DIV
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             rx_en_i,
    input  logic             rx_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_err_o,
    output logic             overrun_o,
    input  logic             clr_err_i,
    output logic             busy_o
);
    rx_state_t state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n, div, half;
    logic [2:0] idx, idx_n;
    logic [7:0] sh, sh_n;
    logic rx_s, fall, tick, deliver, ferr_set;
    uart_rx_sync u_sync (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .rx_i     (rx_i),
        .rx_s     (rx_s),
        .fall     (fall)
    );
    assign div = (baud_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div_i;
    assign half = div >> 1;
    assign tick = cnt == '0;
    assign busy_o = state != IDLE;
    always_comb begin
        state_n = state;
        cnt_n = tick ? cnt : cnt - DIV_W'(1);
        idx_n = idx;
        sh_n = sh;
        deliver = 1'b0;
        ferr_set = 1'b0;
        if (!rx_en_i) state_n = IDLE;
        else begin
            case (state)
                IDLE: if (fall) begin
                    state_n = START;
                    cnt_n = half - DIV_W'(1);
                end
                START: if (tick) begin
                    state_n = rx_s ? IDLE : DATA;
                    cnt_n = div - DIV_W'(1);
                    idx_n = '0;
                end
                DATA: if (tick) begin
                    sh_n = {rx_s, sh[7:1]};
                    cnt_n = div - DIV_W'(1);
                    idx_n = idx + 3'd1;
                    state_n = (idx == 3'(DATA_BITS - 1)) ? STOP : DATA;
                end
                STOP: if (tick) begin
                    state_n = IDLE;
                    deliver = rx_s;
                    ferr_set = ~rx_s;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
            data_o <= '0;
            valid_o <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            sh <= sh_n;
            if (deliver && (!valid_o || ready_i)) data_o <= sh;
            valid_o <= deliver | (valid_o & ~ready_i);
            frame_err_o <= ferr_set | (frame_err_o & ~clr_err_i);
            overrun_o <= (deliver & valid_o & ~ready_i) | (overrun_o & ~clr_err_i);
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core
module tb_uart_rx_core;
    logic clk = 1'b0;
    logic wb_rst_i = 1'b1;
    logic [23:0] baud_div_i = 24'd434;
    logic rx_en_i = 1'b1;
    logic rx_i = 1'b1;
    logic [7:0] data_o;
    logic valid_o;
    logic ready_i = 1'b0;
    logic frame_err_o;
    logic overrun_o;
    logic clr_err_i = 1'b0;
    logic busy_o;
    int cyc = 0;
    int drive_at = 0;
    int busy_at = 0;
    int busy_fall = 0;
    int valid_at = 0;
    logic busy_q = 1'b0;
    logic valid_q = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    uart_rx_core dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .baud_div_i  (baud_div_i),
        .rx_en_i     (rx_en_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .clr_err_i   (clr_err_i),
        .busy_o      (busy_o)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        busy_q <= busy_o;
        valid_q <= valid_o;
        if (busy_o && !busy_q) busy_at <= cyc;
        if (!busy_o && busy_q) busy_fall <= cyc;
        if (valid_o && !valid_q) valid_at <= cyc;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse_ready();
        @(posedge clk); #1 ready_i = 1'b1;
        @(posedge clk); #1 ready_i = 1'b0;
    endtask
    task automatic pulse_clr();
        @(posedge clk); #1 clr_err_i = 1'b1;
        @(posedge clk); #1 clr_err_i = 1'b0;
    endtask
    task automatic send(input logic [7:0] b, input logic stop, input int div,
                        input int ready_at, input int abort_at, input int kind);
        logic [9:0] fr;
        logic aborted;
        fr = {stop, b, 1'b0};
        aborted = 1'b0;
        for (int j = 0; j < 10 * div; j++) begin
            @(posedge clk);
            #1;
            if (j == 0) drive_at = cyc;
            if (!aborted && j % div == 0) rx_i = fr[j / div];
            ready_i = (j == ready_at);
            if (j == abort_at) begin
                check("busy_before_abort", 32'(busy_o), 32'd1);
                if (kind == 1) rx_en_i = 1'b0;
                else wb_rst_i = 1'b1;
            end
            if (abort_at >= 0 && j == abort_at + 1) begin
                aborted = 1'b1;
                rx_i = 1'b1;
                wb_rst_i = 1'b0;
                check("busy_after_abort", 32'(busy_o), 32'd0);
                if (kind == 2) begin
                    check("rst_valid", 32'(valid_o), 32'd0);
                    check("rst_data", 32'(data_o), 32'h00);
                    check("rst_ferr", 32'(frame_err_o), 32'd0);
                    check("rst_ovr", 32'(overrun_o), 32'd0);
                end
            end
        end
        @(posedge clk);
        #1;
        rx_i = 1'b1;
        ready_i = 1'b0;
    endtask
    initial begin
        wait_cycles(5);
        wb_rst_i = 1'b0;
        check("reset_data", 32'(data_o), 32'h00);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_ferr", 32'(frame_err_o), 32'd0);
        check("reset_ovr", 32'(overrun_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        wait_cycles(10);
        send(8'hA5, 1'b1, 434, -1, -1, 0);
        wait_cycles(5);
        check("a5_start_lat", 32'(busy_at - drive_at), 32'd3);
        check("a5_valid_lat", 32'(valid_at - busy_at), 32'd4123);
        check("a5_data", 32'(data_o), 32'hA5);
        check("a5_valid", 32'(valid_o), 32'd1);
        check("a5_ferr", 32'(frame_err_o), 32'd0);
        check("a5_ovr", 32'(overrun_o), 32'd0);
        send(8'h64, 1'b1, 434, 0, -1, 0);
        check("d_data", 32'(data_o), 32'h64);
        send(8'h65, 1'b1, 434, 0, -1, 0);
        check("e_data", 32'(data_o), 32'h65);
        check("de_ovr", 32'(overrun_o), 32'd0);
        pulse_ready();
        wait_cycles(1);
        check("consume_valid", 32'(valid_o), 32'd0);
        wait_cycles(10);
        @(posedge clk);
        #1 rx_i = 1'b0;
        drive_at = cyc;
        wait_cycles(100);
        rx_i = 1'b1;
        wait_cycles(400);
        check("glitch_len", 32'(busy_fall - busy_at), 32'd217);
        check("glitch_busy", 32'(busy_o), 32'd0);
        check("glitch_valid", 32'(valid_o), 32'd0);
        check("glitch_ferr", 32'(frame_err_o), 32'd0);
        send(8'h3C, 1'b0, 434, -1, -1, 0);
        wait_cycles(10);
        check("ferr_set", 32'(frame_err_o), 32'd1);
        check("ferr_valid", 32'(valid_o), 32'd0);
        pulse_clr();
        wait_cycles(1);
        check("ferr_clr", 32'(frame_err_o), 32'd0);
        send(8'h11, 1'b1, 434, -1, -1, 0);
        send(8'h22, 1'b1, 434, -1, -1, 0);
        check("ovr_data", 32'(data_o), 32'h11);
        check("ovr_flag", 32'(overrun_o), 32'd1);
        check("ovr_valid", 32'(valid_o), 32'd1);
        pulse_clr();
        pulse_ready();
        wait_cycles(1);
        check("ovr_clr", 32'(overrun_o), 32'd0);
        check("ovr_consumed", 32'(valid_o), 32'd0);
        send(8'h11, 1'b1, 434, -1, -1, 0);
        send(8'h22, 1'b1, 434, 4125, -1, 0);
        check("same_cycle_data", 32'(data_o), 32'h22);
        check("same_cycle_ovr", 32'(overrun_o), 32'd0);
        check("same_cycle_valid", 32'(valid_o), 32'd1);
        send(8'h77, 1'b1, 434, -1, 4 * 434 + 10, 1);
        wait_cycles(20);
        rx_en_i = 1'b1;
        check("en_abort_data", 32'(data_o), 32'h22);
        check("en_abort_valid", 32'(valid_o), 32'd1);
        check("en_abort_ovr", 32'(overrun_o), 32'd0);
        check("en_abort_ferr", 32'(frame_err_o), 32'd0);
        wait_cycles(10);
        send(8'h99, 1'b1, 434, -1, 6 * 434 + 10, 2);
        wait_cycles(20);
        send(8'h5A, 1'b1, 434, -1, -1, 0);
        wait_cycles(5);
        check("clean_data", 32'(data_o), 32'h5A);
        check("clean_valid", 32'(valid_o), 32'd1);
        check("clean_ferr", 32'(frame_err_o), 32'd0);
        check("clean_ovr", 32'(overrun_o), 32'd0);
        pulse_ready();
        baud_div_i = 24'd1;
        wait_cycles(10);
        send(8'hC3, 1'b1, 4, -1, -1, 0);
        wait_cycles(5);
        check("min_div_lat", 32'(valid_at - busy_at), 32'd38);
        check("min_div_data", 32'(data_o), 32'hC3);
        check("min_div_ferr", 32'(frame_err_o), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
